// File: rtl/keypad_scanner.sv
`default_nettype none
// keypad_scanner: scans a 4x4 active-low matrix keypad one row per tick and
// reports a single debounced held key as a level-valid {row,col} code.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div;
  logic [3:0]         col_meta, col_s;
  logic [1:0]         row_idx, row_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [3:0]         cand_code, cand_nx;
  logic               valid_nx;
  logic [3:0]         code_nx;
  logic               tick;
  logic               any_low;
  logic [1:0]         col_sel;

  assign tick    = (div == DIV_LAST);
  assign any_low = (col_s != 4'hF);
  assign cnt_inc = cnt + CNT_W'(1);

  // Simultaneous keys in one row resolve to the lowest-numbered column.
  always_comb begin
    if (!col_s[0])      col_sel = 2'd0;
    else if (!col_s[1]) col_sel = 2'd1;
    else if (!col_s[2]) col_sel = 2'd2;
    else                col_sel = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div       <= '0;
      col_meta  <= 4'hF;
      col_s     <= 4'hF;
      state     <= SCAN;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      cnt       <= '0;
      cand_code <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      div       <= tick ? '0 : div + DIV_W'(1);
      col_meta  <= col_in;
      col_s     <= col_meta;
      state     <= state_nx;
      row_idx   <= row_nx;
      row_out   <= ~(4'b0001 << row_nx);
      cnt       <= cnt_nx;
      cand_code <= cand_nx;
      key_valid <= valid_nx;
      key_code  <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    cnt_nx   = cnt;
    cand_nx  = cand_code;
    valid_nx = key_valid;
    code_nx  = key_code;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_nx  = {row_idx, col_sel};
            cnt_nx   = CNT_W'(1);
            state_nx = PRESS_DB;
          end else begin
            row_nx = row_idx + 2'd1;
          end
        end
        PRESS_DB: begin
          if (any_low && (col_sel == cand_code[1:0])) begin
            if (cnt_inc == CNT_DONE) begin
              state_nx = HELD;
              valid_nx = 1'b1;
              code_nx  = cand_code;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx   = '0;
            row_nx   = row_idx + 2'd1;
            state_nx = SCAN;
          end
        end
        HELD: begin
          // Only the held key's column matters; any re-press restarts release debounce.
          if (col_s[cand_code[1:0]]) begin
            if (cnt_inc == CNT_DONE) begin
              valid_nx = 1'b0;
              cnt_nx   = '0;
              row_nx   = row_idx + 2'd1;
              state_nx = SCAN;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        default: begin
          state_nx = SCAN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
